// File: rtl/debug_pattern_pkg.sv
// Shared definitions for the debug colour-bar pattern generator and checker:
// command codes, checker states, RGB565 bar colours and the expected-word function.
package debug_pattern_pkg;

    localparam logic [1:0] CMD_PIXEL       = 2'd0;
    localparam logic [1:0] CMD_FRAME_START = 2'd1;
    localparam logic [1:0] CMD_FRAME_END   = 2'd2;
    localparam logic [1:0] CMD_RESERVED    = 2'd3;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        IN_FRAME = 2'd1,
        REPORT   = 2'd2
    } chk_state_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    // Word carries {pixel x+1, pixel x}; each pixel takes the colour of its own bar.
    function automatic logic [31:0] expected_word(input logic [15:0] x,
                                                  input logic [15:0] bar_width);
        logic [2:0] bar_lo;
        logic [2:0] bar_hi;
        bar_lo = 3'(x / bar_width);
        bar_hi = 3'((x + 16'd1) / bar_width);
        return {bar_colour(bar_hi), bar_colour(bar_lo)};
    endfunction

endpackage

// File: rtl/debug_pattern_ref.sv
// Expected colour-bar word source, driven by the x position of the low pixel.
// Used by both the pattern generator and the checker so their patterns agree.
module debug_pattern_ref
    import debug_pattern_pkg::*;
#(
    parameter int FRAME_WIDTH = 640,
    parameter int X_WIDTH     = $clog2(FRAME_WIDTH)
)(
    input  logic [X_WIDTH-1:0] i_x,
    output logic [31:0]        o_word
);

    localparam logic [15:0] BAR_WIDTH = 16'(FRAME_WIDTH / 8);

    logic [15:0] w_x;

    assign w_x    = 16'(i_x);
    assign o_word = expected_word(w_x, BAR_WIDTH);

endmodule

// File: rtl/debug_pattern_checker.sv
// Receive-side checker for the debug colour-bar stream: per-frame pass/fail, mismatch
// and protocol reporting. Optional first-error capture under DEBUG_PATTERN_CHECKER_FIRST_ERR_EN.
module debug_pattern_checker
    import debug_pattern_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CNT_WIDTH    = 16
)(
    input  logic                               clk_cam,
    input  logic                               reset_n,
    input  logic [31:0]                        in_data,
    input  logic [1:0]                         in_command,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic                               frame_done,
    output logic                               frame_ok,
    output logic [CNT_WIDTH-1:0]               mismatch_count,
    output logic [CNT_WIDTH-1:0]               frame_count,
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
    output logic [$clog2(FRAME_WIDTH)-1:0]     first_err_x,
    output logic [$clog2(FRAME_HEIGHT+1)-1:0]  first_err_y,
    output logic [31:0]                        first_err_data,
    output logic                               first_err_valid,
`endif
    output logic                               protocol_error
);

    localparam int XW = $clog2(FRAME_WIDTH);
    localparam int YW = $clog2(FRAME_HEIGHT + 1);
    localparam logic [XW-1:0]        X_LAST   = XW'(FRAME_WIDTH - 2);
    localparam logic [YW-1:0]        Y_FULL   = YW'(FRAME_HEIGHT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    chk_state_t           r_state;
    chk_state_t           w_state_nxt;
    logic                 r_in_ready;
    logic                 r_frame_done;
    logic                 r_frame_ok;
    logic                 r_protocol_error;
    logic [CNT_WIDTH-1:0] r_mismatch_count;
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic                 r_cmp_valid;
    logic                 r_cmp_mismatch;

    logic                 w_accept;
    logic                 w_frame_full;
    logic                 w_pend_mis;
    logic                 w_clear;
    logic                 w_compare;
    logic                 w_perr_set;
    logic                 w_report;
    logic [31:0]          w_exp_word;

    debug_pattern_ref #(
        .FRAME_WIDTH (FRAME_WIDTH),
        .X_WIDTH     (XW)
    ) u_ref (
        .i_x    (r_x),
        .o_word (w_exp_word)
    );

    // The position counters stop at (0, FRAME_HEIGHT) once the last word has been compared.
    assign w_accept     = in_valid && r_in_ready;
    assign w_frame_full = (r_y == Y_FULL);
    assign w_pend_mis   = r_cmp_valid && r_cmp_mismatch;

    // State register
    always_ff @(posedge clk_cam or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_SOF: begin
                if (w_accept && (in_command == CMD_FRAME_START)) begin
                    w_state_nxt = IN_FRAME;
                end else begin
                    w_state_nxt = WAIT_SOF;
                end
            end
            IN_FRAME: begin
                if (w_accept && (in_command == CMD_FRAME_END)) begin
                    w_state_nxt = REPORT;
                end else begin
                    w_state_nxt = IN_FRAME;
                end
            end
            REPORT:  w_state_nxt = WAIT_SOF;
            default: w_state_nxt = WAIT_SOF;
        endcase
    end

    // Per-beat control decode
    always_comb begin
        w_clear    = 1'b0;
        w_compare  = 1'b0;
        w_perr_set = 1'b0;
        w_report   = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                if (!w_accept) begin
                    w_clear = 1'b0;
                end else if (in_command == CMD_FRAME_START) begin
                    w_clear = 1'b1;
                end else begin
                    w_perr_set = 1'b1;
                end
            end
            IN_FRAME: begin
                if (w_accept) begin
                    case (in_command)
                        CMD_PIXEL: begin
                            if (w_frame_full) begin
                                w_perr_set = 1'b1;
                            end else begin
                                w_compare = 1'b1;
                            end
                        end
                        CMD_FRAME_START: begin
                            w_clear    = 1'b1;
                            w_perr_set = 1'b1;
                        end
                        CMD_FRAME_END: w_report   = 1'b1;
                        default:       w_perr_set = 1'b1;
                    endcase
                end else begin
                    w_compare = 1'b0;
                end
            end
            default: w_report = 1'b0;
        endcase
    end

    // Status outputs and counters; a compare still in flight is folded into the report.
    always_ff @(posedge clk_cam or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready       <= 1'b0;
            r_frame_done     <= 1'b0;
            r_frame_ok       <= 1'b0;
            r_protocol_error <= 1'b0;
            r_mismatch_count <= CNT_ZERO;
            r_frame_count    <= CNT_ZERO;
        end else begin
            r_in_ready   <= (w_state_nxt != REPORT);
            r_frame_done <= w_report;
            if (w_report) begin
                r_frame_ok    <= (r_mismatch_count == CNT_ZERO) && !w_pend_mis && w_frame_full;
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
            end
            if (w_perr_set) begin
                r_protocol_error <= 1'b1;
            end
            if (w_clear) begin
                r_mismatch_count <= CNT_ZERO;
            end else if (w_pend_mis && (r_mismatch_count != CNT_MAX)) begin
                r_mismatch_count <= r_mismatch_count + CNT_WIDTH'(1);
            end
        end
    end

    // Pixel position and registered comparison against the reference word
    always_ff @(posedge clk_cam or negedge reset_n) begin
        if (!reset_n) begin
            r_x            <= XW'(0);
            r_y            <= YW'(0);
            r_cmp_valid    <= 1'b0;
            r_cmp_mismatch <= 1'b0;
        end else begin
            r_cmp_valid    <= w_compare;
            r_cmp_mismatch <= w_compare && (in_data != w_exp_word);
            if (w_clear) begin
                r_x <= XW'(0);
                r_y <= YW'(0);
            end else if (w_compare) begin
                if (r_x == X_LAST) begin
                    r_x <= XW'(0);
                    r_y <= r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(2);
                end
            end
        end
    end

`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
    logic [XW-1:0] r_cmp_x;
    logic [YW-1:0] r_cmp_y;
    logic [31:0]   r_cmp_data;
    logic [XW-1:0] r_first_err_x;
    logic [YW-1:0] r_first_err_y;
    logic [31:0]   r_first_err_data;
    logic          r_first_err_valid;

    // Carry the compared word's position alongside the compare, latch the first failure
    always_ff @(posedge clk_cam or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_x           <= XW'(0);
            r_cmp_y           <= YW'(0);
            r_cmp_data        <= 32'h0000_0000;
            r_first_err_x     <= XW'(0);
            r_first_err_y     <= YW'(0);
            r_first_err_data  <= 32'h0000_0000;
            r_first_err_valid <= 1'b0;
        end else begin
            if (w_compare) begin
                r_cmp_x    <= r_x;
                r_cmp_y    <= r_y;
                r_cmp_data <= in_data;
            end
            if (w_clear) begin
                r_first_err_x     <= XW'(0);
                r_first_err_y     <= YW'(0);
                r_first_err_data  <= 32'h0000_0000;
                r_first_err_valid <= 1'b0;
            end else if (w_pend_mis && !r_first_err_valid) begin
                r_first_err_x     <= r_cmp_x;
                r_first_err_y     <= r_cmp_y;
                r_first_err_data  <= r_cmp_data;
                r_first_err_valid <= 1'b1;
            end
        end
    end

    assign first_err_x     = r_first_err_x;
    assign first_err_y     = r_first_err_y;
    assign first_err_data  = r_first_err_data;
    assign first_err_valid = r_first_err_valid;
`endif

    assign in_ready       = r_in_ready;
    assign frame_done     = r_frame_done;
    assign frame_ok       = r_frame_ok;
    assign mismatch_count = r_mismatch_count;
    assign frame_count    = r_frame_count;
    assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_debug_pattern_checker.sv
// Directed bench for debug_pattern_checker on a 16x4 frame with 4-bit counters.
// First-error outputs are checked when DEBUG_PATTERN_CHECKER_FIRST_ERR_EN is defined.
module tb_debug_pattern_checker;

    localparam logic [1:0] C_PIX = 2'd0;
    localparam logic [1:0] C_SOF = 2'd1;
    localparam logic [1:0] C_EOF = 2'd2;

    logic        clk_cam = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  in_command = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        frame_done;
    logic        frame_ok;
    logic [3:0]  mismatch_count;
    logic [3:0]  frame_count;
    logic        protocol_error;
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
    logic [3:0]  first_err_x;
    logic [2:0]  first_err_y;
    logic [31:0] first_err_data;
    logic        first_err_valid;
`endif

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_before;

    debug_pattern_checker #(
        .FRAME_WIDTH  (16),
        .FRAME_HEIGHT (4),
        .CNT_WIDTH    (4)
    ) dut (
        .clk_cam         (clk_cam),
        .reset_n         (reset_n),
        .in_data         (in_data),
        .in_command      (in_command),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .frame_done      (frame_done),
        .frame_ok        (frame_ok),
        .mismatch_count  (mismatch_count),
        .frame_count     (frame_count),
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
        .first_err_x     (first_err_x),
        .first_err_y     (first_err_y),
        .first_err_data  (first_err_data),
        .first_err_valid (first_err_valid),
`endif
        .protocol_error  (protocol_error)
    );

    always #5 clk_cam = ~clk_cam;

    always @(posedge clk_cam) begin
        if (frame_done) done_seen <= done_seen + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bars are 2 pixels wide, so word k of a row is entirely bar k.
    function automatic logic [31:0] exp_word(input int k);
        logic [15:0] c;
        case (k % 8)
            0:       c = 16'hFFFF;
            1:       c = 16'hFFE0;
            2:       c = 16'h07FF;
            3:       c = 16'h07E0;
            4:       c = 16'hF81F;
            5:       c = 16'hF800;
            6:       c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return {c, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one beat and return #1 after the edge that accepts it.
    task automatic send_beat(input logic [1:0] cmd, input logic [31:0] data);
        int guard;
        in_command = cmd;
        in_data    = data;
        in_valid   = 1'b1;
        guard      = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk_cam);
            #1;
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $error("FAIL handshake_timeout observed=%0b expected=1", in_ready);
        end
        @(posedge clk_cam);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int nwords, input int bad_idx, input bit all_bad,
                              input logic [31:0] bad_val);
        logic [31:0] w;
        send_beat(C_SOF, 32'h0);
        for (int k = 0; k < nwords; k++) begin
            w = exp_word(k);
            if (all_bad) w = ~w;
            else if (k == bad_idx) w = bad_val;
            send_beat(C_PIX, w);
        end
        send_beat(C_EOF, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk_cam);
        #1;
        chk("rst_ready", in_ready, 32'd0);
        chk("rst_done", frame_done, 32'd0);
        chk("rst_ok", frame_ok, 32'd0);
        chk("rst_mis", mismatch_count, 32'd0);
        chk("rst_fc", frame_count, 32'd0);
        chk("rst_perr", protocol_error, 32'd0);
        reset_n = 1'b1;
        @(posedge clk_cam);
        #1;
        chk("ready_after_rst", in_ready, 32'd1);

        // Clean frame
        send_frame(32, -1, 1'b0, 32'h0);
        chk("A_done", frame_done, 32'd1);
        chk("A_ready_low", in_ready, 32'd0);
        chk("A_ok", frame_ok, 32'd1);
        chk("A_mis", mismatch_count, 32'd0);
        chk("A_fc", frame_count, 32'd1);
        @(posedge clk_cam);
        #1;
        chk("A_done_end", frame_done, 32'd0);
        chk("A_ready_back", in_ready, 32'd1);
        chk("A_ok_held", frame_ok, 32'd1);
        chk("A_perr", protocol_error, 32'd0);

        // Word 5 (x=10, red bar) corrupted to zero
        send_frame(32, 5, 1'b0, 32'h0000_0000);
        chk("B_done", frame_done, 32'd1);
        chk("B_mis", mismatch_count, 32'd1);
        chk("B_ok", frame_ok, 32'd0);
        chk("B_fc", frame_count, 32'd2);
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
        chk("B_fe_x", first_err_x, 32'd10);
        chk("B_fe_y", first_err_y, 32'd0);
        chk("B_fe_data", first_err_data, 32'h0000_0000);
        chk("B_fe_valid", first_err_valid, 32'd1);
`endif

        // Short frame: 31 words
        send_frame(31, -1, 1'b0, 32'h0);
        chk("C_done", frame_done, 32'd1);
        chk("C_ok", frame_ok, 32'd0);
        chk("C_mis", mismatch_count, 32'd0);
        chk("C_perr", protocol_error, 32'd0);
        chk("C_fc", frame_count, 32'd3);
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
        chk("C_fe_valid", first_err_valid, 32'd0);
`endif

        // Every word wrong: 4-bit count saturates
        send_frame(32, -1, 1'b1, 32'h0);
        chk("D_mis_sat", mismatch_count, 32'd15);
        chk("D_ok", frame_ok, 32'd0);
        chk("D_fc", frame_count, 32'd4);
`ifdef DEBUG_PATTERN_CHECKER_FIRST_ERR_EN
        chk("D_fe_x", first_err_x, 32'd0);
        chk("D_fe_y", first_err_y, 32'd0);
        chk("D_fe_data", first_err_data, 32'h0000_0000);
`endif

        // Pixel outside a frame, then a restarted frame whose aborted part had an error
        @(posedge clk_cam);
        #1;
        send_beat(C_PIX, exp_word(0));
        chk("E_perr_set", protocol_error, 32'd1);
        send_beat(C_SOF, 32'h0);
        for (int k = 0; k < 5; k++) begin
            send_beat(C_PIX, (k == 4) ? 32'h1234_5678 : exp_word(k));
        end
        send_frame(32, -1, 1'b0, 32'h0);
        chk("E_ok", frame_ok, 32'd1);
        chk("E_mis", mismatch_count, 32'd0);
        chk("E_fc", frame_count, 32'd5);
        chk("E_perr_sticky", protocol_error, 32'd1);

        // Reset in the middle of a frame
        @(posedge clk_cam);
        #1;
        send_beat(C_SOF, 32'h0);
        for (int k = 0; k < 10; k++) send_beat(C_PIX, exp_word(k));
        done_before = done_seen;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_cam);
        #1;
        chk("F_no_done", done_seen, done_before);
        chk("F_fc_rst", frame_count, 32'd0);
        chk("F_perr_rst", protocol_error, 32'd0);
        chk("F_ready_rst", in_ready, 32'd0);
        reset_n = 1'b1;
        @(posedge clk_cam);
        #1;
        send_frame(32, -1, 1'b0, 32'h0);
        chk("F_ok", frame_ok, 32'd1);
        chk("F_fc", frame_count, 32'd1);

        // 33rd word is a protocol error and is not compared
        @(posedge clk_cam);
        #1;
        send_frame(33, 32, 1'b0, 32'h0000_0000);
        chk("G_perr", protocol_error, 32'd1);
        chk("G_mis", mismatch_count, 32'd0);
        chk("G_ok", frame_ok, 32'd1);
        chk("G_fc", frame_count, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
